// File: rtl/logic_pipe32.sv
// Bitwise AND/OR/XOR/NOR unit feeding a 2-entry result FIFO.
// Each entry holds the 32-bit result and a zero flag captured at accept time.
module logic_pipe32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        zero,
    output logic [1:0]  count
);

    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [1:0]  zf_q;
    logic [1:0]  zf_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] result;
    logic        accept;
    logic        pop;

    always_comb begin
        unique case (op)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b;
            default: result = ~(a | b);
        endcase
    end

    // Handshake flags depend only on registered state, never on out_ready or in_valid.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        data_d   = data_q;
        zf_d     = zf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            data_d[wr_ptr_q] = result;
            zf_d[wr_ptr_q]   = (result == 32'h0);
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= 32'h0;
            data_q[1] <= 32'h0;
            zf_q      <= 2'b00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            data_q    <= data_d;
            zf_q      <= zf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign out   = out_valid ? data_q[rd_ptr_q] : 32'h0;
    assign zero  = out_valid ? zf_q[rd_ptr_q] : 1'b0;
    assign count = count_q;

endmodule

// File: tb/tb_logic_pipe32.sv
// Directed and randomised checks of logic_pipe32 against a queue scoreboard.
// Inputs change and outputs are sampled around the falling edge.
module tb_logic_pipe32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb[$];

    logic_pipe32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth-table reference: table bit index is {a_bit, b_bit}.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [3:0]  tt;
        logic [31:0] r;
        case (o)
            2'b00:   tt = 4'b1000;
            2'b01:   tt = 4'b1110;
            2'b10:   tt = 4'b0110;
            default: tt = 4'b0001;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [32:0] head;
        head = (sb.size() > 0) ? sb[0] : 33'h0;
        chk("count", {30'h0, count}, sb.size());
        chk("in_ready", {31'h0, in_ready}, {31'h0, sb.size() < 2});
        chk("out_valid", {31'h0, out_valid}, {31'h0, sb.size() > 0});
        chk("out", out, head[31:0]);
        chk("zero", {31'h0, zero}, {31'h0, head[32]});
    endtask

    // One clock of stimulus; exp is the result expected if this op is accepted.
    task automatic cycle(input logic iv, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic ordy, input logic [31:0] exp);
        logic acc_m, pop_m;
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        check_state();
        acc_m = iv && (sb.size() < 2);
        pop_m = ordy && (sb.size() > 0);
        if (pop_m) void'(sb.pop_front());
        if (acc_m) sb.push_back({exp == 32'h0, exp});
    endtask

    task automatic do_reset(input logic busy);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = busy;
        op        = 2'b01;
        a         = 32'hDEAD_BEEF;
        b         = 32'h1;
        out_ready = busy;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        do_reset(1'b0);

        // Single OR op, popped the cycle after it appears.
        cycle(1'b1, 2'b01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'hFFF0_FFF0);
        drain();

        // All four ops in order.
        cycle(1'b1, 2'b00, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'hFF00_0000);
        cycle(1'b1, 2'b01, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'hFFFF_FF00);
        cycle(1'b1, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h00FF_FF00);
        cycle(1'b1, 2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h0000_00FF);
        drain();

        // Zero flag.
        cycle(1'b1, 2'b10, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0);
        cycle(1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0);
        drain();

        // Backpressure: third op refused; full even while out_ready=1.
        cycle(1'b1, 2'b00, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b0, 32'hAAAA_0000);
        cycle(1'b1, 2'b01, 32'h0000_0001, 32'h0000_0100, 1'b0, 32'h0000_0101);
        cycle(1'b1, 2'b10, 32'h5555_5555, 32'h0, 1'b0, 32'h5555_5555);
        cycle(1'b1, 2'b10, 32'h5555_5555, 32'h0, 1'b1, 32'h5555_5555);
        drain();

        // Pass-through at count=1.
        cycle(1'b1, 2'b00, 32'h0000_FFFF, 32'h0000_00F0, 1'b0, 32'h0000_00F0);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; ro = 2'(i);
            cycle(1'b1, ro, ra, rb, 1'b1, model(ro, ra, rb));
        end
        drain();

        // Reset while full discards both entries.
        cycle(1'b1, 2'b01, 32'h1, 32'h2, 1'b0, 32'h3);
        cycle(1'b1, 2'b01, 32'h4, 32'h8, 1'b0, 32'hC);
        do_reset(1'b1);
        cycle(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            ro = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), ro, ra, rb, 1'($urandom_range(0, 1)),
                  model(ro, ra, rb));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
